// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between IF and ID: owns the fetch PC, buffers {pc, instr} entries.
// Optional combinational empty-queue bypass enabled by defining FETCH_BUFFER_BYPASS_EN.
module fetch_buffer #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_MASK = 32'h0000007F
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     id_stall,
  output logic                     id_valid,
  output logic [31:0]              id_instr,
  output logic [31:0]              id_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];

  logic          w_head_valid;
  logic          w_bypass;
  logic          w_pop;
  logic          w_fetch;
  logic          w_write;
  logic          w_pop_mem;
  logic [31:0]   w_fetch_pc_next;
  logic [31:0]   w_redirect_target;

  assign w_head_valid = (r_count != '0);

`ifdef FETCH_BUFFER_BYPASS_EN
  assign w_bypass = ~w_head_valid & ~redirect;
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    id_valid = w_head_valid;
    id_instr = 32'h0;
    id_pc    = 32'h0;
    if (w_head_valid) begin
      id_instr = r_mem_instr[r_rd_ptr];
      id_pc    = r_mem_pc[r_rd_ptr];
    end else if (w_bypass) begin
      id_valid = 1'b1;
      id_instr = imem_rdata;
      id_pc    = r_fetch_pc;
    end
  end

  // A bypassed word consumed by decode advances the PC but never touches storage.
  assign w_pop             = id_valid & ~id_stall & ~redirect;
  assign w_fetch           = ~redirect & ((r_count < FULL) | w_pop);
  assign w_write           = w_fetch & ~(w_bypass & w_pop);
  assign w_pop_mem         = w_pop & ~w_bypass;
  assign w_fetch_pc_next   = (r_fetch_pc + 32'd4) & PC_MASK;
  assign w_redirect_target = redirect_pc & PC_MASK & ~32'h3;

  assign imem_addr = r_fetch_pc;
  assign count     = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= 32'h0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else if (redirect) begin
      r_fetch_pc <= w_redirect_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_fetch)   r_fetch_pc <= w_fetch_pc_next;
      if (w_write)   r_wr_ptr   <= r_wr_ptr + AW'(1);
      if (w_pop_mem) r_rd_ptr   <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_write) - CW'(w_pop_mem);
    end
  end

  // Storage carries no reset; head outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: doc/fetch_buffer.md
# fetch_buffer

Instruction prefetch queue between the IF stage (program counter plus combinational instruction memory) and the ID stage of the 5-stage RV32 pipeline. It owns the fetch PC and keeps fetching sequentially into a small FIFO of {pc, instruction} entries. It presents the oldest entry to decode, holds that entry while decode stalls, and flushes everything on a taken-branch redirect from ID.

## Interface
Parameters:
- DEPTH, 4: number of queue entries; power of two, 2..16.
- PC_MASK, 32'h0000007F: fetch address mask matching the 128-byte instruction memory.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- imem_addr  out  32  address driven to instruction memory; equals fetch_pc.
- imem_rdata  in  32  instruction word read combinationally at imem_addr in the same cycle.
- redirect  in  1  taken branch resolved in ID (PCSrc).
- redirect_pc  in  32  branch target.
- id_stall  in  1  decode cannot accept this cycle (load-use hazard stall).
- id_valid  out  1  head entry valid.
- id_instr  out  32  head instruction; 32'h0 (bubble) when id_valid=0.
- id_pc  out  32  PC of head instruction; 32'h0 when id_valid=0.
- count  out  $clog2(DEPTH)+1  current number of occupied entries.

## Operation
- State: fetch_pc (32), DEPTH-entry storage of {pc, instr}, rd_ptr/wr_ptr ($clog2(DEPTH) bits each, wrap modulo DEPTH), count.
- pop = id_valid & ~id_stall & ~redirect.
- push = ~redirect & (count < DEPTH | pop). A push writes {fetch_pc, imem_rdata} at wr_ptr and advances fetch_pc to (fetch_pc + 4) & PC_MASK. 0x7C wraps to 0x00.
- With no push, fetch_pc holds.
- Full (count == DEPTH) with pop: push and pop occur in the same cycle and count stays at DEPTH.
- Empty with no push: id_valid stays 0.
- Redirect has the highest priority, regardless of id_stall. On the next edge: all entries are discarded (count=0, rd_ptr=wr_ptr=0) and fetch_pc <= redirect_pc & PC_MASK & ~32'h3. No push and no pop happen in the redirect cycle.
- count update: count + push − pop.
- Head outputs are read from storage at rd_ptr, gated to zero when count==0.

## Timing
- Reset values: fetch_pc=0, count=0, pointers=0, id_valid=0, id_instr=0, id_pc=0, imem_addr=0.
- Reset asserted mid-operation clears state asynchronously. Outputs go to reset values without waiting for a clock edge.
- First cycle after reset deasserts (cycle 0): fetch at pc 0 is pushed at edge 0. In cycle 1, id_valid=1 with id_pc=0.
- Fetch-to-decode latency: 1 cycle. An instruction fetched in cycle n is visible at the head no earlier than cycle n+1.
- Redirect asserted in cycle n: cycle n+1 has id_valid=0 and imem_addr=target. The target instruction is at the head in cycle n+2.
- Under id_stall, the head entry and its outputs are held stable. Fetching continues until count==DEPTH.
- Storage is not reset; only pointers and count are. Invalid head outputs are forced to 0 by gating, not by storage contents.

## Configuration
- FETCH_BUFFER_BYPASS_EN defined: when count==0 and redirect=0, the head outputs come combinationally from the fetch path: id_valid=1, id_instr=imem_rdata, id_pc=fetch_pc.
  - If that word is popped in the same cycle (id_stall=0), it is not written into storage: fetch_pc advances and count stays 0.
  - If id_stall=1, the word is pushed normally.
  - Fetch-to-decode latency becomes 0. After a redirect, the target is at the head in cycle n+1.
- Undefined: no bypass; latencies as in Timing.

## Test plan
- Reset release, id_stall=0 and imem returning its address as data → id_pc sequence 0x00, 0x04, 0x08, … starting in cycle 1; after 0x7C the next id_pc is 0x00; count stays ≤1.
- id_stall held for 6 cycles from id_pc=0x08 → id_instr/id_pc frozen at 0x08; count rises to 4 and saturates; imem_addr stops at 0x18. On release, the queue drains 0x08, 0x0C, 0x10, 0x14 in order, then 0x18.
- Full queue, then a redirect with redirect_pc=0x44 in cycle n → cycle n+1: id_valid=0, count=0, imem_addr=0x44. Cycle n+2: id_pc=0x44 (bypass: cycle n+1).
- Redirect and id_stall asserted together with count=3 → redirect wins, the queue is flushed, and the stalled head is not popped or retained.
- redirect_pc=0x1C3 → fetch_pc becomes 0x40 (masked and aligned).
- Reset pulsed asynchronously mid-cycle with count=2 → id_valid, id_pc, id_instr, count and imem_addr all go to 0 before the next clock edge.
